fir_mac_scheduler: RTL and testbench
====================================

# fir_mac_scheduler

Time-multiplexed FIR engine and scheduler. It shares one signed 8x8 multiply-accumulate unit among NCH independent sample streams, with a round-robin arbiter granting one channel at a time. Each granted sample is pushed into that channel's private delay line, and a 4-tap convolution is computed serially, one tap per cycle. The block sits between the per-channel sample sources and the downstream consumer, and includes a coefficient-programming port shared by all channels.

## Interface
- NCH, 4, number of channels (power of 2, 2..8)
- TAPS, 4, taps per filter (fixed to 4 in this revision)
- DW, 8, signed sample width
- CW, 8, signed coefficient width
- OW, 16, accumulator and output width
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- s_valid  in  NCH  per-channel sample valid
- s_data  in  NCH*DW  per-channel samples; channel c occupies bits [c*DW +: DW]
- s_ready  out  NCH  one-hot grant; sample of channel c is accepted when s_valid[c] && s_ready[c]
- cfg_we  in  1  coefficient write strobe
- cfg_addr  in  2  tap index 0..3
- cfg_data  in  CW  signed coefficient value
- cfg_ready  out  1  high when a write is accepted (state IDLE)
- m_valid  out  1  result valid
- m_data  out  OW  signed filter output
- m_chan  out  log2(NCH)  channel the result belongs to
- m_ready  in  1  consumer accept

## Operation
- Storage:
  - Per channel c, delay line x_c[0..3] (x_c[0] is the newest sample).
  - Shared coefficient set h[0..3].
  - Round-robin pointer `last`, the most recently granted channel.
- FSM states: IDLE, MAC, OUT.
- IDLE:
  - cfg_ready = 1.
  - If cfg_we: write h[cfg_addr] <= cfg_data. s_ready = 0 this cycle, so configuration wins over samples.
  - Else, if any s_valid: grant g = first channel with s_valid set, searching last+1, last+2, ... modulo NCH. s_ready[g] = 1, combinational, in IDLE only.
  - On accept: shift x_g (x_g[3]<=x_g[2], x_g[2]<=x_g[1], x_g[1]<=x_g[0], x_g[0]<=sample), last <= g, acc <= 0, k <= 0, go to MAC.
- MAC:
  - One tap per cycle: acc <= acc + h[k]*x_g[k], k increments.
  - The operand is the post-shift delay line.
  - After k = 3, go to OUT.
  - cfg_we is ignored and s_ready = 0.
- OUT:
  - m_valid = 1, m_data = acc, m_chan = g.
  - Outputs are held stable until m_ready.
  - On m_valid && m_ready, go to IDLE.
- Arithmetic:
  - Products are signed CW x DW, sign-extended to OW.
  - Accumulation is two's-complement, modulo 2^OW. No saturation.
  - Result = sum over k of h[k]*x_g[k], mod 2^OW.
- Channels never share delay-line state. A channel's line shifts only when that channel is granted.

## Timing
- Reset values:
  - state IDLE; s_ready 0 (it also stays 0 until the first IDLE cycle after reset); cfg_ready 1.
  - m_valid 0, m_data 0, m_chan 0.
  - All delay lines 0, acc 0, k 0.
  - h = {1, 2, 3, 4}.
  - last = NCH-1, so channel 0 has first priority.
- Latency: sample accepted at edge T; MAC edges T+1..T+4; m_valid is high in the cycle after edge T+4.
- Throughput: 6 cycles per sample at m_ready = 1 (1 IDLE + 4 MAC + 1 OUT).
- s_valid deasserting while not granted is legal; it is not sticky.
- A cfg_we outside IDLE is dropped with no effect. The source must check cfg_ready.
- A coefficient write takes effect on the next accepted sample.
- Reset asserted mid-MAC or mid-OUT: immediate return to the reset values listed above, no result emitted, coefficients restored to defaults.

## Test plan
- Impulse, ch0 only, default coefficients: samples 1, 0, 0, 0, 0 -> m_data 1, 2, 3, 4, 0 with m_chan 0. First m_valid 5 cycles after accept.
- Round-robin: all 4 s_valid held high, each sample 1 -> grants in order ch0, ch1, ch2, ch3, ch0. Every channel's first result is 1, second is 3 (1+2).
- Backpressure: m_ready low for 10 cycles in OUT -> m_valid, m_data and m_chan hold stable, s_ready stays 0, no sample lost. Then m_ready pulse -> IDLE next cycle.
- Config:
  - Write h = {-1, 0, 0, 2} in IDLE while s_valid[1] is high -> s_ready stays 0 during the writes.
  - Ch1 samples 5, 0, 0, 7 -> outputs -5, 0, 0, 3.
  - cfg_we during MAC -> ignored.
- Wrap: h all -128, a channel fed -128 four times -> 4th output 4*16384 = 65536 mod 2^16 = 0. 3rd output 49152, which reads as -16384 signed.
- Reset at 2nd MAC cycle -> next cycle m_valid 0, all delay lines 0, h = {1, 2, 3, 4}. Impulse test then passes unchanged.

Source files
------------

// File: rtl/fir_mac_scheduler.sv
// Time-multiplexed 4-tap FIR engine: a round-robin arbiter grants one of NCH
// sample streams at a time, the granted sample is shifted into that channel's
// private delay line, and one shared signed MAC walks the taps serially.
module fir_mac_scheduler #(
  parameter int NCH  = 4,
  parameter int TAPS = 4,
  parameter int DW   = 8,
  parameter int CW   = 8,
  parameter int OW   = 16,
  localparam int CHW = $clog2(NCH),
  localparam int KW  = $clog2(TAPS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NCH-1:0]      s_valid,
  input  logic [NCH*DW-1:0]   s_data,
  output logic [NCH-1:0]      s_ready,
  input  logic                cfg_we,
  input  logic [1:0]          cfg_addr,
  input  logic [CW-1:0]       cfg_data,
  output logic                cfg_ready,
  output logic                m_valid,
  output logic [OW-1:0]       m_data,
  output logic [CHW-1:0]      m_chan,
  input  logic                m_ready
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MAC  = 2'd1;
  localparam logic [1:0] ST_OUT  = 2'd2;

  logic [1:0]           state_q, state_d;
  logic signed [DW-1:0] x_q [NCH][TAPS];
  logic signed [CW-1:0] h_q [TAPS];
  logic [CHW-1:0]       last_q, g_q;
  logic signed [OW-1:0] acc_q;
  logic [KW-1:0]        k_q;

  logic                 grant_found;
  logic [CHW-1:0]       grant_idx;
  logic [CHW-1:0]       cand;
  logic                 accept;
  logic signed [DW-1:0] samp;

  // One tap: signed CW x DW product, sign-extended, accumulated modulo 2^OW.
  function automatic logic signed [OW-1:0] mac_step(
    input logic signed [OW-1:0] acc,
    input logic signed [CW-1:0] coef,
    input logic signed [DW-1:0] x
  );
    logic signed [CW+DW-1:0] prod;
    prod = coef * x;
    return acc + OW'(prod);
  endfunction

  // Round-robin search starting just after the last granted channel; NCH is a
  // power of two so the index wraps naturally in CHW bits.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 1; i <= NCH; i++) begin
      cand = last_q + CHW'(i);
      if (!grant_found && s_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Grant only in IDLE with no coefficient write pending; held low during reset.
  always_comb begin
    accept  = (state_q == ST_IDLE) && !reset && !cfg_we && grant_found;
    samp    = s_data[int'(grant_idx)*DW +: DW];
    s_ready = '0;
    if (accept) s_ready[grant_idx] = 1'b1;
  end

  // Next-state logic for the IDLE -> MAC -> OUT sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_MAC;
      ST_MAC:  if (k_q == KW'(TAPS-1)) state_d = ST_OUT;
      ST_OUT:  if (m_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, delay lines, coefficients and the MAC datapath.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      last_q  <= CHW'(NCH-1);
      g_q     <= '0;
      acc_q   <= '0;
      k_q     <= '0;
      for (int c = 0; c < NCH; c++)
        for (int t = 0; t < TAPS; t++)
          x_q[c][t] <= '0;
      for (int t = 0; t < TAPS; t++)
        h_q[t] <= CW'(t + 1);
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (cfg_we) begin
            h_q[cfg_addr] <= cfg_data;
          end else if (accept) begin
            for (int t = TAPS-1; t > 0; t--)
              x_q[grant_idx][t] <= x_q[grant_idx][t-1];
            x_q[grant_idx][0] <= samp;
            last_q <= grant_idx;
            g_q    <= grant_idx;
            acc_q  <= '0;
            k_q    <= '0;
          end
        end
        ST_MAC: begin
          acc_q <= mac_step(acc_q, h_q[k_q], x_q[g_q][k_q]);
          k_q   <= k_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign cfg_ready = (state_q == ST_IDLE);
  assign m_valid   = (state_q == ST_OUT);
  assign m_data    = acc_q;
  assign m_chan    = g_q;

endmodule

// File: tb/tb_fir_mac_scheduler.sv
// Directed bench for fir_mac_scheduler: stimulus pushes hand-computed results
// into a queue, a negedge monitor pops and compares on every handshake.
module tb_fir_mac_scheduler;
  localparam int NCH = 4;
  localparam int DW  = 8;
  localparam int CW  = 8;
  localparam int OW  = 16;
  localparam int CHW = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [NCH-1:0]    s_valid;
  logic [NCH*DW-1:0] s_data;
  logic [NCH-1:0]    s_ready;
  logic              cfg_we;
  logic [1:0]        cfg_addr;
  logic [CW-1:0]     cfg_data;
  logic              cfg_ready;
  logic              m_valid;
  logic [OW-1:0]     m_data;
  logic [CHW-1:0]    m_chan;
  logic              m_ready;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [CHW-1:0] ch;
    logic [OW-1:0]  d;
  } exp_t;
  exp_t sb[$];

  fir_mac_scheduler #(.NCH(NCH), .TAPS(4), .DW(DW), .CW(CW), .OW(OW)) dut (
    .clk(clk), .reset(reset),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_ready(cfg_ready),
    .m_valid(m_valid), .m_data(m_data), .m_chan(m_chan), .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every accepted output is matched against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (m_valid === 1'b1 && m_ready === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got chan %0d data %0h with nothing expected", m_chan, m_data);
        end else begin
          e = sb.pop_front();
          chk("out_data", 32'(m_data), 32'(e.d));
          chk("out_chan", 32'(m_chan), 32'(e.ch));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Wait for the next grant, check it goes to ch, optionally queue the result.
  task automatic wait_accept(input int ch, input int exp_val, input bit push);
    int n;
    exp_t e;
    n = 0;
    while (1) begin
      @(negedge clk);
      if ((s_ready & s_valid) != '0) break;
      n++;
      if (n > 100) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: ch%0d never granted", ch);
        return;
      end
    end
    chk("grant", 32'(s_ready), 32'(1 << ch));
    if (push) begin
      e.ch = CHW'(ch);
      e.d  = OW'(exp_val);
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int ch, input int val, input int exp_val, input bit push);
    s_valid[ch] = 1'b1;
    s_data[ch*DW +: DW] = DW'(val);
    wait_accept(ch, exp_val, push);
    s_valid[ch] = 1'b0;
  endtask

  task automatic cfg_write(input int addr, input int val);
    cfg_we   = 1'b1;
    cfg_addr = 2'(addr);
    cfg_data = CW'(val);
    @(negedge clk);
    chk("cfg_blocks_sready", 32'(s_ready), 32'd0);
    chk("cfg_ready_idle", 32'(cfg_ready), 32'd1);
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d results outstanding expected 0", sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic impulse();
    send(0, 1, 1, 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("latency_early", 32'(m_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("latency_on", 32'(m_valid), 32'd1);
    send(0, 0, 2, 1);
    send(0, 0, 3, 1);
    send(0, 0, 4, 1);
    send(0, 0, 0, 1);
    drain();
  endtask

  initial begin
    reset    = 1'b0;
    s_valid  = '1;
    s_data   = '0;
    cfg_we   = 1'b0;
    cfg_addr = '0;
    cfg_data = '0;
    m_ready  = 1'b1;
    #1 reset = 1'b1;
    @(negedge clk);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);
    chk("rst_m_chan", 32'(m_chan), 32'd0);
    chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    chk("rst_s_ready", 32'(s_ready), 32'd0);

    // Round-robin: every channel valid with sample 1.
    for (int c = 0; c < NCH; c++) s_data[c*DW +: DW] = 8'd1;
    @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 8; i++) wait_accept(i % NCH, (i < NCH) ? 1 : 3, 1);
    s_valid = '0;
    drain();

    // Impulse on ch0 with default coefficients.
    do_reset();
    impulse();

    // Backpressure: ch2 result held while ch3 waits.
    m_ready = 1'b0;
    s_valid[3] = 1'b1;
    s_data[3*DW +: DW] = 8'd7;
    send(2, 4, 4, 1);
    repeat (4) @(posedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_m_valid", 32'(m_valid), 32'd1);
      chk("bp_m_data", 32'(m_data), 32'd4);
      chk("bp_m_chan", 32'(m_chan), 32'd2);
      chk("bp_s_ready", 32'(s_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_idle_after_ready", 32'(cfg_ready), 32'd1);
    wait_accept(3, 7, 1);
    s_valid[3] = 1'b0;
    drain();

    // Coefficient programming with ch1 pending.
    do_reset();
    s_valid[1] = 1'b1;
    s_data[1*DW +: DW] = 8'd5;
    cfg_write(0, -1);
    cfg_write(1, 0);
    cfg_write(2, 0);
    cfg_write(3, 2);
    wait_accept(1, -5, 1);
    s_valid[1] = 1'b0;
    send(1, 0, 0, 1);
    cfg_we   = 1'b1;
    cfg_addr = 2'd0;
    cfg_data = 8'd100;
    @(negedge clk);
    chk("mac_cfg_ready", 32'(cfg_ready), 32'd0);
    repeat (3) @(posedge clk);
    #1 cfg_we = 1'b0;
    send(1, 0, 0, 1);
    send(1, 7, 3, 1);
    drain();

    // Modulo wrap with all coefficients -128.
    do_reset();
    for (int t = 0; t < 4; t++) cfg_write(t, -128);
    send(2, -128, 16384, 1);
    send(2, -128, 32768, 1);
    send(2, -128, 49152, 1);
    send(2, -128, 0, 1);
    drain();

    // Reset during the second MAC cycle, then the impulse test again.
    send(0, 9, 0, 0);
    @(posedge clk);
    #1;
    s_valid[1] = 1'b1;
    reset = 1'b1;
    #1;
    chk("midrst_m_valid", 32'(m_valid), 32'd0);
    chk("midrst_m_data", 32'(m_data), 32'd0);
    chk("midrst_m_chan", 32'(m_chan), 32'd0);
    chk("midrst_s_ready", 32'(s_ready), 32'd0);
    chk("midrst_cfg_ready", 32'(cfg_ready), 32'd1);
    repeat (2) @(posedge clk);
    s_valid[1] = 1'b0;
    #1 reset = 1'b0;
    impulse();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
